// File: rtl/memory_resp.sv
// memory_resp: two-lane data-cache request/response tracker with per-lane FSMs and load alignment.
// Define MEM_RESP_BYPASS_EN to forward cache data to rdata_o combinationally in the data_ok cycle.
package memory_resp_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;
endpackage

module memory_resp
  import memory_resp_pkg::*;
#(
  parameter int LANES = 2
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  dbus_req_t  [LANES-1:0] req_i,
  input  logic       [LANES-1:0] sext_i,
  input  logic                   adv_i,
  input  logic                   flush_i,
  output dbus_req_t  [LANES-1:0] dreq_o,
  input  dbus_resp_t [LANES-1:0] resp_i,
  output logic [LANES-1:0][31:0] rdata_o,
  output logic                   stall_o
);

  typedef enum logic [2:0] {IDLE, REQ, DATA, DONE, DRAIN} lane_state_e;

`ifdef MEM_RESP_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  lane_state_e [LANES-1:0] state_q, state_d;
  dbus_req_t   [LANES-1:0] req_q, req_d;
  logic        [LANES-1:0] sext_q, sext_d;
  logic [LANES-1:0][31:0]  rdata_q, rdata_d;
  logic [LANES-1:0][31:0]  fmt_data;
  logic        [LANES-1:0] completing;
  logic        [LANES-1:0] lane_ok;
  logic        [LANES-1:0] lane_busy;
  logic        [LANES-1:0] accept;
  logic                    pair_done;

  function automatic logic [31:0] format_load(input logic [1:0]  offset,
                                              input logic [1:0]  size,
                                              input logic        is_store,
                                              input logic        sext,
                                              input logic [31:0] raw);
    logic [31:0] shifted;
    logic [31:0] result;
    shifted = raw >> {offset, 3'b000};
    case (size)
      2'd0:    result = {{24{sext & shifted[7]}}, shifted[7:0]};
      2'd1:    result = {{16{sext & shifted[15]}}, shifted[15:0]};
      default: result = shifted;
    endcase
    if (is_store) result = '0;
    return result;
  endfunction

  // A lane "completes" in the cycle its data beat lands; with bypass that already counts as done.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      fmt_data[l]   = format_load(req_q[l].addr[1:0], req_q[l].size, |req_q[l].strobe,
                                  sext_q[l], resp_i[l].data);
      completing[l] = !flush_i && resp_i[l].data_ok &&
                      (state_q[l] == DATA || (state_q[l] == REQ && resp_i[l].addr_ok));
      lane_ok[l]    = (state_q[l] == IDLE) || (state_q[l] == DONE) || (BYPASS && completing[l]);
      lane_busy[l]  = ((state_q[l] == REQ || state_q[l] == DATA || state_q[l] == DRAIN) &&
                       !(BYPASS && completing[l])) ||
                      (state_q[l] == IDLE && req_i[l].valid);
    end
  end

  assign pair_done = &lane_ok;
  assign stall_o   = resetn && (|lane_busy);

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      rdata_o[l] = (BYPASS && completing[l]) ? fmt_data[l] : rdata_q[l];
      dreq_o[l]  = '0;
      if (state_q[l] == REQ && !flush_i) begin
        dreq_o[l]       = req_q[l];
        dreq_o[l].valid = 1'b1;
      end
    end
  end

  // Flush beats adv and new requests; a flushed DATA lane must still swallow its pending beat.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      state_d[l] = state_q[l];
      req_d[l]   = req_q[l];
      sext_d[l]  = sext_q[l];
      rdata_d[l] = rdata_q[l];
      accept[l]  = 1'b0;
      case (state_q[l])
        IDLE: begin
          if (!flush_i && req_i[l].valid) accept[l] = 1'b1;
        end
        REQ: begin
          if (flush_i) begin
            state_d[l] = IDLE;
          end else if (resp_i[l].addr_ok) begin
            if (resp_i[l].data_ok) begin
              rdata_d[l] = fmt_data[l];
              state_d[l] = DONE;
            end else begin
              state_d[l] = DATA;
            end
          end
        end
        DATA: begin
          if (flush_i) begin
            state_d[l] = resp_i[l].data_ok ? IDLE : DRAIN;
          end else if (resp_i[l].data_ok) begin
            rdata_d[l] = fmt_data[l];
            state_d[l] = DONE;
          end
        end
        DONE: begin
          if (flush_i) begin
            state_d[l] = IDLE;
          end else if (adv_i && pair_done) begin
            if (req_i[l].valid) accept[l] = 1'b1;
            else                state_d[l] = IDLE;
          end
        end
        DRAIN: begin
          if (resp_i[l].data_ok) state_d[l] = IDLE;
        end
        default: state_d[l] = IDLE;
      endcase
      if (BYPASS && completing[l] && adv_i && pair_done) begin
        if (req_i[l].valid) accept[l] = 1'b1;
        else                state_d[l] = IDLE;
      end
      if (accept[l]) begin
        state_d[l] = REQ;
        req_d[l]   = req_i[l];
        sext_d[l]  = sext_i[l];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int l = 0; l < LANES; l++) state_q[l] <= IDLE;
      req_q   <= '0;
      sext_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      sext_q  <= sext_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_memory_resp.sv
// tb_memory_resp: directed and randomized scenarios for memory_resp, checked against a
// transaction-level model (handshake timeline per lane plus arithmetic load formatting).
module tb_memory_resp;
  import memory_resp_pkg::*;

  logic                  clk;
  logic                  resetn;
  dbus_req_t  [1:0]      req_i;
  logic       [1:0]      sext_i;
  logic                  adv_i;
  logic                  flush_i;
  dbus_req_t  [1:0]      dreq_o;
  dbus_resp_t [1:0]      resp_i;
  logic [1:0][31:0]      rdata_o;
  logic                  stall_o;

  int total;
  int bad;
  logic [31:0] expRdata [2];

`ifdef MEM_RESP_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    bit        active;
    bit [31:0] addr;
    bit [1:0]  size;
    bit [3:0]  strobe;
    bit [31:0] wdata;
    bit        sext;
    bit [31:0] rawData;
    int        addrLat;
    int        dataLat;
  } txn_t;

  memory_resp #(.LANES(2)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .req_i   (req_i),
    .sext_i  (sext_i),
    .adv_i   (adv_i),
    .flush_i (flush_i),
    .dreq_o  (dreq_o),
    .resp_i  (resp_i),
    .rdata_o (rdata_o),
    .stall_o (stall_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not end");
    $fatal(1, "[TB] watchdog");
  end

  // Reference load formatting: pick the addressed bytes, then extend by value range.
  function automatic logic [31:0] expected_load(input txn_t t);
    logic [31:0] v;
    int sh;
    if (t.strobe != 0) return 32'd0;
    sh = int'(t.addr % 4);
    v = t.rawData >> (8 * sh);
    if (t.size == 0) begin
      v = v % 256;
      if (t.sext && v >= 128) v = v - 256;
    end else if (t.size == 1) begin
      v = v % 65536;
      if (t.sext && v >= 32768) v = v - 65536;
    end
    return v;
  endfunction

  function automatic txn_t mk(input bit active, input bit [31:0] addr, input bit [1:0] size,
                              input bit [3:0] strobe, input bit sext, input bit [31:0] raw,
                              input int aLat, input int dLat);
    txn_t t;
    t.active  = active;
    t.addr    = addr;
    t.size    = size;
    t.strobe  = strobe;
    t.wdata   = $urandom;
    t.sext    = sext;
    t.rawData = raw;
    t.addrLat = aLat;
    t.dataLat = dLat;
    return t;
  endfunction

  function automatic txn_t rand_txn(input bit active);
    bit [3:0] strobe;
    strobe = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
    return mk(active, $urandom, 2'($urandom_range(0, 2)), strobe, ($urandom_range(0, 1) == 1),
              $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
  endfunction

  task automatic set_idle();
    req_i   = '0;
    sext_i  = '0;
    adv_i   = 1'b0;
    flush_i = 1'b0;
    resp_i  = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Plays one pair through its whole cache timeline and checks stall, dreq and rdata each cycle.
  task automatic drive_pair(input txn_t t0, input txn_t t1, input string name);
    txn_t t [2];
    int tA [2];
    int tD [2];
    int maxTD;
    int advCycle;
    dbus_req_t e;
    logic [31:0] want;
    t[0] = t0;
    t[1] = t1;
    maxTD = 0;
    for (int l = 0; l < 2; l++) begin
      tA[l] = 1 + t[l].addrLat;
      tD[l] = tA[l] + t[l].dataLat;
      if (t[l].active && tD[l] > maxTD) maxTD = tD[l];
    end
    advCycle = BYPASS ? maxTD : maxTD + 1;
    for (int c = 0; c <= advCycle; c++) begin
      for (int l = 0; l < 2; l++) begin
        req_i[l]       = '0;
        sext_i[l]      = 1'b0;
        resp_i[l]      = '0;
        resp_i[l].data = $urandom;
        if (t[l].active) begin
          if (c == 0) begin
            req_i[l].valid  = 1'b1;
            req_i[l].addr   = t[l].addr;
            req_i[l].size   = t[l].size;
            req_i[l].strobe = t[l].strobe;
            req_i[l].data   = t[l].wdata;
            sext_i[l]       = t[l].sext;
          end else if (c < advCycle) begin
            req_i[l].valid  = ($urandom_range(0, 1) == 1);
            req_i[l].addr   = $urandom;
            req_i[l].size   = 2'($urandom_range(0, 3));
            req_i[l].strobe = 4'($urandom_range(0, 15));
            req_i[l].data   = $urandom;
            sext_i[l]       = ($urandom_range(0, 1) == 1);
          end
          resp_i[l].addr_ok = (c == tA[l]);
          resp_i[l].data_ok = (c == tD[l]);
          if (c == tD[l]) resp_i[l].data = t[l].rawData;
        end else begin
          resp_i[l].addr_ok = ($urandom_range(0, 1) == 1);
          resp_i[l].data_ok = ($urandom_range(0, 1) == 1);
        end
      end
      adv_i   = (c == advCycle) ? 1'b1 : ($urandom_range(0, 1) == 1);
      flush_i = 1'b0;
      @(negedge clk);
      total++;
      if (stall_o !== (c < advCycle)) begin
        bad++;
        $display("[TB] FAIL %s stall c=%0d: got %b want %b", name, c, stall_o, (c < advCycle));
      end
      for (int l = 0; l < 2; l++) begin
        if (t[l].active && c >= 1 && c <= tA[l]) begin
          e        = '0;
          e.valid  = 1'b1;
          e.addr   = t[l].addr;
          e.size   = t[l].size;
          e.strobe = t[l].strobe;
          e.data   = t[l].wdata;
          total++;
          if (dreq_o[l] !== e) begin
            bad++;
            $display("[TB] FAIL %s dreq%0d c=%0d: got %h want %h", name, l, c, dreq_o[l], e);
          end
        end else begin
          total++;
          if (dreq_o[l].valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s dreq%0d.valid c=%0d: got %b want 0", name, l, c, dreq_o[l].valid);
          end
        end
        if (c == advCycle) begin
          want = t[l].active ? expected_load(t[l]) : expRdata[l];
          total++;
          if (rdata_o[l] !== want) begin
            bad++;
            $display("[TB] FAIL %s rdata%0d: got %h want %h", name, l, rdata_o[l], want);
          end
          expRdata[l] = want;
        end
      end
      next_cycle();
    end
    set_idle();
    @(negedge clk);
    total++;
    if (stall_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s idle stall: got %b want 0", name, stall_o);
    end
    next_cycle();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    set_idle();
    req_i[0].valid = 1'b1;
    req_i[1].valid = 1'b1;
    #3;
    total++;
    if (stall_o !== 1'b0) begin bad++; $display("[TB] FAIL reset stall: got %b want 0", stall_o); end
    for (int l = 0; l < 2; l++) begin
      total++;
      if (dreq_o[l] !== '0) begin bad++; $display("[TB] FAIL reset dreq%0d: got %h want 0", l, dreq_o[l]); end
      total++;
      if (rdata_o[l] !== 32'd0) begin bad++; $display("[TB] FAIL reset rdata%0d: got %h want 0", l, rdata_o[l]); end
      expRdata[l] = 32'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    set_idle();
    @(negedge clk);
    total++;
    if (stall_o !== 1'b0) begin bad++; $display("[TB] FAIL post-reset stall: got %b want 0", stall_o); end
    next_cycle();
  endtask

  task automatic test_single_lane();
    drive_pair(mk(1, 32'h0000_1002, 2'd1, 4'd0, 1'b0, 32'h8001_1234, 0, 1),
               mk(0, 0, 0, 0, 0, 0, 0, 0), "lhu_lane0");
    drive_pair(mk(0, 0, 0, 0, 0, 0, 0, 0),
               mk(1, 32'h0000_2003, 2'd0, 4'd0, 1'b1, 32'h80FF_FFFF, 0, 1), "lb_lane1");
  endtask

  task automatic test_both_lanes();
    drive_pair(mk(1, 32'h0000_3000, 2'd2, 4'd0, 1'b0, $urandom, 0, 4),
               mk(1, 32'h0000_3104, 2'd2, 4'd0, 1'b0, $urandom, 0, 1), "skewed_pair");
  endtask

  task automatic test_same_cycle();
    drive_pair(mk(1, 32'h0000_4000, 2'd2, 4'd0, 1'b0, 32'h1234_5678, 0, 0),
               mk(0, 0, 0, 0, 0, 0, 0, 0), "same_cycle_word");
  endtask

  task automatic test_store();
    drive_pair(mk(1, 32'h0000_5000, 2'd2, 4'hF, 1'b0, $urandom, 1, 1),
               mk(1, 32'h0000_5101, 2'd0, 4'h2, 1'b1, 32'hFFFF_FFFF, 0, 2), "store_pair");
  endtask

  task automatic test_flush();
    txn_t t;
    // Flush while waiting for data: the late beat must be drained, not captured.
    set_idle();
    req_i[0].valid = 1'b1;
    req_i[0].addr  = $urandom;
    req_i[0].size  = 2'd2;
    @(negedge clk);
    total++;
    if (stall_o !== 1'b1) begin bad++; $display("[TB] FAIL flushA accept stall: got %b want 1", stall_o); end
    next_cycle();
    set_idle();
    resp_i[0].addr_ok = 1'b1;
    @(negedge clk);
    total++;
    if (dreq_o[0].valid !== 1'b1) begin bad++; $display("[TB] FAIL flushA dreq.valid: got %b want 1", dreq_o[0].valid); end
    next_cycle();
    set_idle();
    flush_i = 1'b1;
    @(negedge clk);
    total++;
    if (stall_o !== 1'b1) begin bad++; $display("[TB] FAIL flushA flush stall: got %b want 1", stall_o); end
    next_cycle();
    set_idle();
    resp_i[0].data_ok = 1'b1;
    resp_i[0].data    = $urandom;
    @(negedge clk);
    total++;
    if (stall_o !== 1'b1) begin bad++; $display("[TB] FAIL flushA drain stall: got %b want 1", stall_o); end
    total++;
    if (rdata_o[0] !== expRdata[0]) begin bad++; $display("[TB] FAIL flushA drain rdata: got %h want %h", rdata_o[0], expRdata[0]); end
    next_cycle();
    set_idle();
    @(negedge clk);
    total++;
    if (stall_o !== 1'b0) begin bad++; $display("[TB] FAIL flushA after stall: got %b want 0", stall_o); end
    total++;
    if (rdata_o[0] !== expRdata[0]) begin bad++; $display("[TB] FAIL flushA after rdata: got %h want %h", rdata_o[0], expRdata[0]); end
    next_cycle();
    drive_pair(rand_txn(1), mk(0, 0, 0, 0, 0, 0, 0, 0), "flush_reissue");

    // Flush in REQ drops valid the same cycle, even if the cache says addr_ok.
    set_idle();
    req_i[1].valid = 1'b1;
    req_i[1].addr  = $urandom;
    next_cycle();
    set_idle();
    flush_i = 1'b1;
    resp_i[1].addr_ok = 1'b1;
    @(negedge clk);
    total++;
    if (dreq_o[1].valid !== 1'b0) begin bad++; $display("[TB] FAIL flushB dreq.valid: got %b want 0", dreq_o[1].valid); end
    next_cycle();
    set_idle();
    @(negedge clk);
    total++;
    if (stall_o !== 1'b0) begin bad++; $display("[TB] FAIL flushB after stall: got %b want 0", stall_o); end
    next_cycle();

    // Flush beats a new request presented in the same cycle.
    set_idle();
    req_i[0].valid = 1'b1;
    req_i[0].addr  = $urandom;
    flush_i = 1'b1;
    next_cycle();
    set_idle();
    @(negedge clk);
    total++;
    if (dreq_o[0].valid !== 1'b0) begin bad++; $display("[TB] FAIL flushC dreq.valid: got %b want 0", dreq_o[0].valid); end
    total++;
    if (stall_o !== 1'b0) begin bad++; $display("[TB] FAIL flushC stall: got %b want 0", stall_o); end
    next_cycle();

    // Flush in DONE beats adv plus a new request; captured data stays visible.
    t = rand_txn(1);
    t.strobe = 4'd0;
    set_idle();
    req_i[0].valid = 1'b1;
    req_i[0].addr  = t.addr;
    req_i[0].size  = t.size;
    sext_i[0]      = t.sext;
    next_cycle();
    set_idle();
    resp_i[0].addr_ok = 1'b1;
    resp_i[0].data_ok = 1'b1;
    resp_i[0].data    = t.rawData;
    next_cycle();
    set_idle();
    flush_i = 1'b1;
    adv_i   = 1'b1;
    req_i[0].valid = 1'b1;
    req_i[0].addr  = $urandom;
    next_cycle();
    set_idle();
    @(negedge clk);
    total++;
    if (dreq_o[0].valid !== 1'b0) begin bad++; $display("[TB] FAIL flushD dreq.valid: got %b want 0", dreq_o[0].valid); end
    total++;
    if (stall_o !== 1'b0) begin bad++; $display("[TB] FAIL flushD stall: got %b want 0", stall_o); end
    total++;
    if (rdata_o[0] !== expected_load(t)) begin bad++; $display("[TB] FAIL flushD rdata: got %h want %h", rdata_o[0], expected_load(t)); end
    expRdata[0] = expected_load(t);
    next_cycle();
  endtask

  task automatic test_random();
    txn_t a;
    txn_t b;
    for (int i = 0; i < 40; i++) begin
      a = rand_txn($urandom_range(0, 1) == 1);
      b = rand_txn($urandom_range(0, 1) == 1);
      if (!a.active && !b.active) a.active = 1'b1;
      drive_pair(a, b, "random");
    end
  endtask

  task automatic test_reset_mid();
    drive_pair(mk(1, 32'h0000_6000, 2'd2, 4'd0, 1'b0, 32'hDEAD_BEEF, 0, 1),
               mk(1, 32'h0000_6100, 2'd2, 4'd0, 1'b0, 32'h0BAD_F00D, 1, 0), "pre_reset");
    set_idle();
    req_i[0].valid = 1'b1;
    req_i[0].addr  = 32'h0000_7000;
    req_i[0].size  = 2'd2;
    next_cycle();
    set_idle();
    resp_i[0].addr_ok = 1'b1;
    next_cycle();
    set_idle();
    req_i[1].valid = 1'b1;
    #1;
    resetn = 1'b0;
    #1;
    total++;
    if (stall_o !== 1'b0) begin bad++; $display("[TB] FAIL midreset stall: got %b want 0", stall_o); end
    for (int l = 0; l < 2; l++) begin
      total++;
      if (dreq_o[l] !== '0) begin bad++; $display("[TB] FAIL midreset dreq%0d: got %h want 0", l, dreq_o[l]); end
      total++;
      if (rdata_o[l] !== 32'd0) begin bad++; $display("[TB] FAIL midreset rdata%0d: got %h want 0", l, rdata_o[l]); end
      expRdata[l] = 32'd0;
    end
    next_cycle();
    resetn = 1'b1;
    set_idle();
    resp_i[0].data_ok = 1'b1;
    resp_i[0].data    = 32'hCAFE_F00D;
    @(negedge clk);
    total++;
    if (stall_o !== 1'b0) begin bad++; $display("[TB] FAIL stray stall: got %b want 0", stall_o); end
    total++;
    if (rdata_o[0] !== 32'd0) begin bad++; $display("[TB] FAIL stray rdata: got %h want 0", rdata_o[0]); end
    next_cycle();
    set_idle();
    @(negedge clk);
    total++;
    if (rdata_o[0] !== 32'd0) begin bad++; $display("[TB] FAIL stray after rdata: got %h want 0", rdata_o[0]); end
    total++;
    if (dreq_o[0].valid !== 1'b0) begin bad++; $display("[TB] FAIL stray after dreq.valid: got %b want 0", dreq_o[0].valid); end
    next_cycle();
    drive_pair(rand_txn(1), rand_txn(1), "post_reset");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single_lane();
    test_both_lanes();
    test_same_cycle();
    test_store();
    test_flush();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_resp.md
MEMORY_RESP -- requirements
Module: memory_resp

Interface
REQ-001 SHALL have parameter LANES, default 2, meaning number of issue lanes; only 2 is supported; lane 1 is the older instruction.
REQ-002 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port resetn  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_i  in  dbus_req_t[1:0]  per-lane request from memory stage (valid, addr, size, strobe, data).
REQ-005 SHALL have port sext_i  in  2  per-lane load sign-extend flag.
REQ-006 SHALL have port adv_i  in  1  downstream stage accepts the current pair this cycle.
REQ-007 SHALL have port flush_i  in  1  discard all in-flight lanes.
REQ-008 SHALL have port dreq_o  out  dbus_req_t[1:0]  requests presented to the data cache.
REQ-009 SHALL have port resp_i  in  dbus_resp_t[1:0]  cache response (addr_ok, data_ok, data[31:0]).
REQ-010 SHALL have port rdata_o  out  32x2  aligned, extended load data per lane.
REQ-011 SHALL have port stall_o  out  1  pair not complete; upstream holds.

Function
REQ-012 SHALL keep one FSM per lane with states IDLE, REQ, DATA, DONE, DRAIN.
REQ-013 IDLE->REQ SHALL occur when req_i.valid=1 and flush_i=0.
REQ-014 In REQ, dreq_o SHALL equal the latched request with valid=1; REQ->DATA on addr_ok=1.
REQ-015 Request fields SHALL be latched on IDLE->REQ and held stable until addr_ok; req_i changes in REQ/DATA are ignored.
REQ-016 DATA->DONE SHALL occur on data_ok=1; resp_i.data is captured into a per-lane register.
REQ-017 DONE->IDLE SHALL occur on adv_i=1 when both lanes are DONE or IDLE; DONE->REQ instead if req_i.valid=1 that cycle.
REQ-018 Addr_ok and data_ok in the same cycle SHALL move REQ directly to DONE.
REQ-019 stall_o SHALL be 1 while any lane is in REQ, DATA or DRAIN, or a lane is IDLE with req_i.valid=1 and not yet accepted.
REQ-020 rdata_o SHALL be captured data shifted right by 8*addr[1:0].
REQ-021 rdata_o SHALL be extended per size: size 0 = byte, size 1 = halfword, size 2 = word, using sign extension if sext_i else zero extension.
REQ-022 Stores (strobe!=0) SHALL follow the same FSM; rdata_o for a store lane is 0.
REQ-023 flush_i=1 SHALL move REQ/DONE to IDLE with dreq_o.valid dropped the same cycle.
REQ-024 flush_i=1 SHALL move DATA to DRAIN; DRAIN discards the data_ok beat, then goes IDLE; stall_o=1 while any lane is in DRAIN.
REQ-025 flush_i SHALL take priority over adv_i and over a new req_i.valid in the same cycle.
REQ-026 Lanes SHALL proceed independently; no ordering is enforced between lane 0 and lane 1 cache handshakes.

Reset
REQ-027 resetn=0 SHALL immediately force both FSMs to IDLE.
REQ-028 resetn=0 SHALL immediately force dreq_o to all-zero, rdata_o to 0 and stall_o to 0.
REQ-029 Reset mid-transaction SHALL abandon the transaction; any data_ok arriving after release while IDLE SHALL be ignored.

Configuration
REQ-030 Macro MEM_RESP_BYPASS_EN, when defined, SHALL forward resp_i.data combinationally to rdata_o in the data_ok cycle; stall_o deasserts that same cycle if the pair completes.
REQ-031 Without MEM_RESP_BYPASS_EN, rdata_o SHALL come only from the capture register; stall_o deasserts one cycle after the last data_ok.

Verification
REQ-032 Lane 1 lb at addr 0x..3, data 0x80FF_FFFF, sext=1, addr_ok and data_ok one cycle apart -> rdata_o[1]=0xFFFF_FF80, stall_o high until completion.
REQ-033 Lane 0 lhu at addr 0x..2, data 0x8001_1234 -> rdata_o[0]=0x0000_8001; lane 1 idle -> stall depends only on lane 0.
REQ-034 Both lanes loads; lane 0 data_ok 3 cycles after lane 1 -> stall_o held until lane 0 DONE; adv_i returns both lanes to IDLE together.
REQ-035 flush_i in DATA state, then data_ok next cycle -> DRAIN for 1 cycle, rdata_o unchanged, next request issues cleanly.
REQ-036 Same-cycle addr_ok and data_ok, word load 0x1234_5678 -> rdata_o=0x1234_5678; stall low same cycle with MEM_RESP_BYPASS_EN, one cycle later without.
REQ-037 resetn low while lane in DATA -> outputs zero immediately; stray data_ok after release -> no state change.
